alu_mdu_seq: RTL and testbench
==============================

// Module: alu_mdu_seq
// PURPOSE
//  Parametrised, handshaked successor to the combinational RV32I ALU. Executes the
//  19 base ALU ops (ALUSel 0..18) with a 1-cycle registered result. Adds the RV M-ext
//  ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an iterative XLEN-cycle unit.
//  Sits in the EX stage; the pipeline stalls on in_ready/out_valid.
// PARAMETERS
//  XLEN    32  operand/result width (>=8, power of 2); shift amount = in2[$clog2(XLEN)-1:0]
//  SEL_W   5   width of ALUSel
//  MDU_EN  1   1: M-ext ops supported; 0: codes 19..26 treated as illegal
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operation request
//  in_ready   out  1      block can accept a request (high only in IDLE)
//  in1        in   XLEN   operand A (rs1)
//  in2        in   XLEN   operand B (rs2/imm)
//  ALUSel     in   SEL_W  op code, see BEHAVIOUR
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      consumer accepts result
//  out        out  XLEN   result
//  illegal    out  1      qualifies out_valid: op code unsupported, out=0
// BEHAVIOUR
//  Op codes: 0 ADDI,1 SLTI,2 SLTIU,3 XORI,4 ORI,5 ANDI,6 SLLI,7 SRLI,8 SRAI,9 ADD,
//   10 SUB,11 SLL,12 SLT,13 SLTU,14 XOR,15 SRL,16 SRA,17 OR,18 AND,19 MUL,20 MULH,
//   21 MULHSU,22 MULHU,23 DIV,24 DIVU,25 REM,26 REMU; 27..31 (or 19..26 if !MDU_EN) illegal.
//  Reset: state=IDLE, in_ready=1, out_valid=0, out=0, illegal=0; all internal regs cleared.
//  FSM: IDLE -> (in_valid & base/illegal op) DONE; IDLE -> (in_valid & M op) BUSY;
//   BUSY -> after XLEN iterations DONE; DONE -> (out_ready) IDLE.
//  Handshake: request is accepted on the edge where in_valid & in_ready. Operands and ALUSel
//   are captured then; input changes after acceptance are ignored.
//  Latency: base/illegal op: out_valid on the cycle after acceptance. M op: out_valid
//   XLEN+1 cycles after acceptance. out/illegal stay stable while out_valid & !out_ready.
//  out_valid and out_ready are sampled in DONE. in_ready=1 only in IDLE, so there is no
//   back-to-back overlap: throughput is at most one op per 2 cycles.
//  Arithmetic: ADD/SUB wrap mod 2^XLEN. SLT/SLTI are signed; SLTU/SLTIU unsigned; result 0/1.
//   SRA/SRAI sign-fill.
//  MUL: low XLEN bits. MULH: s*s high. MULHSU: signed in1 * unsigned in2 high. MULHU: u*u high.
//  Div by zero: DIV/DIVU -> all ones; REM/REMU -> in1.
//  Signed overflow (in1=-2^(XLEN-1), in2=-1): DIV -> in1; REM -> 0. Both still take XLEN+1 cycles.
//  Remainder takes the sign of the dividend (RISC-V truncating division).
//  rst asserted mid-BUSY/DONE: abort immediately, pending result discarded, return to reset values.
// STRUCTURE
//  alu_pkg: op code localparams (ALU_ADDI..ALU_REMU), FSM state encodings, NUM_OPS=27.
//  Sub-module alu_muldiv_iter: start/op/a/b in, busy/done/result out.
//   - Multiply: shift-add on magnitudes, sign fix at end.
//   - Divide: restoring divide on magnitudes, sign fix at end.
//  Top holds the FSM, the base-op combinational datapath, and the output registers.
// TESTING
//  1 Reset: assert rst mid-run -> in_ready=1, out_valid=0, out=0 the same cycle.
//  2 Base: ALUSel=16, in1=-16, in2=2 -> out=-4 one cycle after accept.
//   ALUSel=13, in1=-1, in2=1 -> out=0 (unsigned compare).
//  3 MUL family, XLEN=32: in1=0xFFFFFFFF, in2=2:
//   MUL -> 0xFFFFFFFE; MULH -> 0xFFFFFFFF; MULHU -> 1; MULHSU -> 0xFFFFFFFF.
//   out_valid exactly 33 cycles after accept.
//  4 DIV/REM corners: 7/0 -> DIV=0xFFFFFFFF, REM=7; 0x80000000/-1 -> DIV=0x80000000, REM=0;
//   -7/2 -> DIV=-3, REM=-1.
//  5 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out stable, in_ready=0;
//   change in1 while BUSY -> result unaffected.
//  6 Illegal: ALUSel=30 -> out_valid with illegal=1, out=0; MDU_EN=0 with ALUSel=19 -> illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and iterative-unit op encoding for alu_mdu_seq.
package alu_pkg;

  // ALUSel op codes
  localparam int unsigned ALU_ADDI   = 0;
  localparam int unsigned ALU_SLTI   = 1;
  localparam int unsigned ALU_SLTIU  = 2;
  localparam int unsigned ALU_XORI   = 3;
  localparam int unsigned ALU_ORI    = 4;
  localparam int unsigned ALU_ANDI   = 5;
  localparam int unsigned ALU_SLLI   = 6;
  localparam int unsigned ALU_SRLI   = 7;
  localparam int unsigned ALU_SRAI   = 8;
  localparam int unsigned ALU_ADD    = 9;
  localparam int unsigned ALU_SUB    = 10;
  localparam int unsigned ALU_SLL    = 11;
  localparam int unsigned ALU_SLT    = 12;
  localparam int unsigned ALU_SLTU   = 13;
  localparam int unsigned ALU_XOR    = 14;
  localparam int unsigned ALU_SRL    = 15;
  localparam int unsigned ALU_SRA    = 16;
  localparam int unsigned ALU_OR     = 17;
  localparam int unsigned ALU_AND    = 18;
  localparam int unsigned ALU_MUL    = 19;
  localparam int unsigned ALU_MULH   = 20;
  localparam int unsigned ALU_MULHSU = 21;
  localparam int unsigned ALU_MULHU  = 22;
  localparam int unsigned ALU_DIV    = 23;
  localparam int unsigned ALU_DIVU   = 24;
  localparam int unsigned ALU_REM    = 25;
  localparam int unsigned ALU_REMU   = 26;

  localparam int unsigned NUM_BASE = 19;
  localparam int unsigned NUM_OPS  = 27;

  // Top-level control FSM
  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  // M-extension op as seen by the iterative unit (ALUSel - ALU_MUL)
  typedef enum logic [2:0] {
    MD_MUL,
    MD_MULH,
    MD_MULHSU,
    MD_MULHU,
    MD_DIV,
    MD_DIVU,
    MD_REM,
    MD_REMU
  } mdu_op_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per cycle
// on operand magnitudes, sign correction applied combinationally on the final value.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   hi, lo, m;
  mdu_op_t           op_q;
  logic              neg_p, neg_q, neg_r;

  logic              a_sgn, b_sgn, sa, sb, div_op;
  logic [XLEN-1:0]   ma, mb;
  logic [XLEN:0]     mul_sum, r_sh, diff;
  logic [XLEN-1:0]   nxt_hi, nxt_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  // Operand signedness and magnitudes at start
  always_comb begin
    a_sgn  = op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_sgn  = op inside {MD_MULH, MD_DIV, MD_REM};
    sa     = a_sgn & a[XLEN-1];
    sb     = b_sgn & b[XLEN-1];
    ma     = sa ? -a : a;
    mb     = sb ? -b : b;
    div_op = op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  end

  // One iteration: hi/lo hold {partial product} for multiply, {remainder, quotient} for divide
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    r_sh    = {hi, lo[XLEN-1]};
    diff    = r_sh - {1'b0, m};
    nxt_hi  = hi;
    nxt_lo  = lo;
    if (op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) begin
      if (!diff[XLEN]) begin
        nxt_hi = diff[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = r_sh[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // Iteration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      op_q  <= MD_MUL;
      neg_p <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      op_q  <= op;
      hi    <= '0;
      lo    <= div_op ? ma : mb;
      m     <= div_op ? mb : ma;
      neg_p <= sa ^ sb;
      // divide-by-zero quotient stays all ones regardless of dividend sign
      neg_q <= (sa ^ sb) && (b != '0);
      neg_r <= sa;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      hi  <= nxt_hi;
      lo  <= nxt_lo;
    end
  end

  // Completion flag and sign-corrected result selection
  always_comb begin
    done   = busy && (cnt == CW'(XLEN));
    prod   = {hi, lo};
    prod_s = neg_p ? -prod : prod;
    quo_s  = neg_q ? -lo : lo;
    rem_s  = neg_r ? -hi : hi;
    case (op_q)
      MD_MUL:                      result = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result = quo_s;
      default:                     result = rem_s;
    endcase
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// Handshaked RV32I ALU with iterative M-extension unit; registered result with valid/ready.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned SEL_W  = 5,
  parameter bit          MDU_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in1,
  input  logic [XLEN-1:0]  in2,
  input  logic [SEL_W-1:0] ALUSel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_t          state, nxt;
  logic [31:0]     sel;
  logic            is_m, is_ill, accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic            mdu_busy, mdu_done;
  logic [XLEN-1:0] mdu_result;
  mdu_op_t         mdu_op;

  // Op decode and base-op combinational datapath
  always_comb begin
    sel      = 32'(ALUSel);
    is_m     = MDU_EN && (sel >= ALU_MUL) && (sel <= ALU_REMU);
    is_ill   = (sel >= NUM_BASE) && !is_m;
    shamt    = in2[SHW-1:0];
    mdu_op   = mdu_op_t'(3'(sel - ALU_MUL));
    base_res = '0;
    case (sel)
      ALU_ADDI, ALU_ADD:   base_res = in1 + in2;
      ALU_SUB:             base_res = in1 - in2;
      ALU_SLTI, ALU_SLT:   base_res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
      ALU_SLTIU, ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, in1 < in2};
      ALU_XORI, ALU_XOR:   base_res = in1 ^ in2;
      ALU_ORI, ALU_OR:     base_res = in1 | in2;
      ALU_ANDI, ALU_AND:   base_res = in1 & in2;
      ALU_SLLI, ALU_SLL:   base_res = in1 << shamt;
      ALU_SRLI, ALU_SRL:   base_res = in1 >> shamt;
      ALU_SRAI, ALU_SRA:   base_res = $unsigned($signed(in1) >>> shamt);
      default:             base_res = '0;
    endcase
  end

  // Handshake status
  always_comb begin
    in_ready  = (state == S_IDLE) && !mdu_busy;
    out_valid = (state == S_DONE);
    accept    = in_valid && in_ready;
  end

  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .start (accept && is_m),
    .op    (mdu_op),
    .a     (in1),
    .b     (in2),
    .busy  (mdu_busy),
    .done  (mdu_done),
    .result(mdu_result)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (accept) nxt = is_m ? S_BUSY : S_DONE;
      S_BUSY:  if (mdu_done) nxt = S_DONE;
      S_DONE:  if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Result registers: loaded on base/illegal accept or on M-unit completion, held in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= '0;
      illegal <= 1'b0;
    end else if (accept && !is_m) begin
      out     <= is_ill ? '0 : base_res;
      illegal <= is_ill;
    end else if (state == S_BUSY && mdu_done) begin
      out     <= mdu_result;
      illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed self-checking bench for alu_mdu_seq (XLEN=32) plus an MDU_EN=0 instance.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, v0, r0;
  logic [31:0] in1, in2;
  logic [4:0]  ALUSel;
  logic        in_ready, out_valid, illegal;
  logic [31:0] out;
  logic        in_ready0, out_valid0, illegal0;
  logic [31:0] out0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mdu_seq #(.XLEN(32), .SEL_W(5), .MDU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .ALUSel(ALUSel), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .illegal(illegal)
  );

  alu_mdu_seq #(.XLEN(32), .SEL_W(5), .MDU_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(in_ready0),
    .in1(in1), .in2(in2), .ALUSel(ALUSel), .out_valid(out_valid0),
    .out_ready(r0), .out(out0), .illegal(illegal0)
  );

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ill;
    int          lat;
    string       nm;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e, input logic il, input int lat, input string n);
    vec_t v;
    v.sel = s; v.a = a; v.b = b; v.exp = e; v.ill = il; v.lat = lat; v.nm = n;
    tv.push_back(v);
  endtask

  // Issue one op, scramble inputs after accept, measure latency, optionally stall, then drain
  task automatic run(input vec_t v, input int hold);
    int cyc;
    @(negedge clk);
    chk({v.nm, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in1 = v.a; in2 = v.b; ALUSel = v.sel; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in1 = ~v.a; in2 = ~v.b; ALUSel = 5'd9;
    cyc = 0;
    while (1) begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid) break;
      if (cyc > 100) begin
        errors++;
        $display("FAIL %s timeout: got no out_valid after %0d cycles, required %0d", v.nm, cyc, v.lat);
        break;
      end
    end
    chk({v.nm, " latency"}, 32'(cyc), 32'(v.lat));
    chk({v.nm, " out"}, out, v.exp);
    chk({v.nm, " illegal"}, 32'(illegal), 32'(v.ill));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({v.nm, " hold out"}, out, v.exp);
      chk({v.nm, " hold valid"}, 32'(out_valid), 32'd1);
      chk({v.nm, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({v.nm, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; v0 = 1'b0; r0 = 1'b0;
    in1 = '0; in2 = '0; ALUSel = '0;

    add(5'd16, 32'hFFFFFFF0, 32'd2,        32'hFFFFFFFC, 1'b0, 1,  "SRA");
    add(5'd13, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1,  "SLTU");
    add(5'd12, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1,  "SLT");
    add(5'd9,  32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1,  "ADD");
    add(5'd10, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1,  "SUB");
    add(5'd11, 32'd1,        32'd35,       32'd8,        1'b0, 1,  "SLL");
    add(5'd15, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1,  "SRL");
    add(5'd8,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1,  "SRAI");
    add(5'd14, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1,  "XOR");
    add(5'd17, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1,  "OR");
    add(5'd18, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1,  "AND");
    add(5'd0,  32'd10,       32'hFFFFFFFD, 32'd7,        1'b0, 1,  "ADDI");
    add(5'd2,  32'd5,        32'hFFFFFFFF, 32'd1,        1'b0, 1,  "SLTIU");
    add(5'd1,  32'd5,        32'hFFFFFFFF, 32'd0,        1'b0, 1,  "SLTI");
    add(5'd19, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, 33, "MUL");
    add(5'd20, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 33, "MULH");
    add(5'd22, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 33, "MULHU");
    add(5'd21, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 33, "MULHSU");
    add(5'd19, 32'h00012345, 32'h100,      32'h01234500, 1'b0, 33, "MUL2");
    add(5'd20, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33, "MULH2");
    add(5'd23, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, 33, "DIV0");
    add(5'd25, 32'd7,        32'd0,        32'd7,        1'b0, 33, "REM0");
    add(5'd23, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b0, 33, "DIVN0");
    add(5'd25, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b0, 33, "REMN0");
    add(5'd24, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 33, "DIVU0");
    add(5'd26, 32'd5,        32'd0,        32'd5,        1'b0, 33, "REMU0");
    add(5'd23, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33, "DIVOVF");
    add(5'd25, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 33, "REMOVF");
    add(5'd23, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33, "DIVNEG");
    add(5'd25, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33, "REMNEG");
    add(5'd24, 32'd100,      32'd7,        32'd14,       1'b0, 33, "DIVU");
    add(5'd26, 32'd100,      32'd7,        32'd2,        1'b0, 33, "REMU");
    add(5'd30, 32'd5,        32'd6,        32'd0,        1'b1, 1,  "ILL30");

    // Reset values
    @(posedge clk);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out", out, 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tv[i]) run(tv[i], 0);

    // Backpressure on an M op with operands scrambled while busy
    v.sel = 5'd22; v.a = 32'hFFFFFFFF; v.b = 32'd2; v.exp = 32'd1; v.ill = 1'b0;
    v.lat = 33; v.nm = "BP_MULHU";
    run(v, 5);

    // Reset asserted mid-BUSY takes effect without waiting for a clock edge
    @(negedge clk);
    in_valid = 1'b1; in1 = 32'd1234; in2 = 32'd5; ALUSel = 5'd19;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("busy in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out", out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst no stale result", 32'(out_valid), 32'd0);

    // Reset asserted while DONE discards the held result
    v.sel = 5'd9; v.a = 32'd40; v.b = 32'd2; v.exp = 32'd42; v.ill = 1'b0;
    v.lat = 1; v.nm = "POSTRST_ADD";
    @(negedge clk);
    in_valid = 1'b1; in1 = v.a; in2 = v.b; ALUSel = v.sel;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("done out", out, 32'd42);
    rst = 1'b1;
    #1;
    chk("donerst out_valid", 32'(out_valid), 32'd0);
    chk("donerst out", out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(v, 0);

    // MDU_EN=0 instance: M op codes are illegal, base ops still work
    @(negedge clk);
    v0 = 1'b1; in1 = 32'd3; in2 = 32'd5; ALUSel = 5'd19;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    chk("nomdu valid", 32'(out_valid0), 32'd1);
    chk("nomdu illegal", 32'(illegal0), 32'd1);
    chk("nomdu out", out0, 32'd0);
    @(negedge clk);
    r0 = 1'b1;
    @(posedge clk);
    #1;
    r0 = 1'b0;
    chk("nomdu drained", 32'(out_valid0), 32'd0);
    @(negedge clk);
    v0 = 1'b1; in1 = 32'd3; in2 = 32'd5; ALUSel = 5'd9;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    chk("nomdu add out", out0, 32'd8);
    chk("nomdu add illegal", 32'(illegal0), 32'd0);
    @(negedge clk);
    r0 = 1'b1;
    @(posedge clk);
    #1;
    r0 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
